// File: rtl/fifo_wr_ctrl_if.sv
// Write-side handshake, RAM write port, pointer and flag bundle
// for the async FIFO write controller.
interface fifo_wr_ctrl_if #(
  parameter int AW = 4
);
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW:0]   rptr_gray_sync;
  logic [AW-1:0] waddr;
  logic          wen;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wlevel;

  modport slave (
    input  s_axis_tvalid,
    input  rptr_gray_sync,
    output s_axis_tready,
    output waddr,
    output wen,
    output wptr_gray,
    output full,
    output almost_full,
    output wlevel
  );

  modport master (
    output s_axis_tvalid,
    output rptr_gray_sync,
    input  s_axis_tready,
    input  waddr,
    input  wen,
    input  wptr_gray,
    input  full,
    input  almost_full,
    input  wlevel
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: write pointer (bin/Gray),
// RAM write strobe, and full / almost_full / level flags.
module fifo_wr_ctrl #(
  parameter int AW        = 4,
  parameter int AFULL_THR = 14
) (
  input logic             clk,
  input logic             rst_n,
  fifo_wr_ctrl_if.slave   bus
);
  localparam logic [AW:0] THR = (AW+1)'(AFULL_THR);

  logic [AW:0] r_wptr_bin;
  logic [AW:0] r_wptr_gray;
  logic [AW:0] r_wlevel;
  logic        r_full;
  logic        r_afull;

  logic        w_tready;
  logic        w_push;
  logic [AW:0] w_bin_next;
  logic [AW:0] w_gray_next;
  logic [AW:0] w_rbin;
  logic [AW:0] w_diff;
  logic [AW:0] w_full_cmp;

  assign w_tready    = rst_n & ~r_full;
  assign w_push      = bus.s_axis_tvalid & w_tready;
  assign w_bin_next  = r_wptr_bin + {{AW{1'b0}}, w_push};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Gray-to-binary: each bit is the XOR of all bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= AW; i++) begin
      w_rbin[i] = ^(bus.rptr_gray_sync >> i);
    end
  end

  assign w_diff     = w_bin_next - w_rbin;
  assign w_full_cmp = {~bus.rptr_gray_sync[AW:AW-1],
                       bus.rptr_gray_sync[AW-2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr_bin  <= '0;
      r_wptr_gray <= '0;
      r_wlevel    <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
    end else begin
      r_wptr_bin  <= w_bin_next;
      r_wptr_gray <= w_gray_next;
      r_wlevel    <= w_diff;
      r_full      <= (w_gray_next == w_full_cmp);
      r_afull     <= (w_diff >= THR);
    end
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.wen           = w_push;
  assign bus.waddr         = r_wptr_bin[AW-1:0];
  assign bus.wptr_gray     = r_wptr_gray;
  assign bus.full          = r_full;
  assign bus.almost_full   = r_afull;
  assign bus.wlevel        = r_wlevel;
endmodule
